// File: rtl/key_sched_pkg.sv
// Shared types for the key-driven SDRAM test command scheduler.
// Holds the command and state encodings and the FIFO pointer width helper.
package key_sched_pkg;

   typedef enum logic [1:0] {
      CMD_WRITE    = 2'd0,
      CMD_READ     = 2'd1,
      CMD_ADDR_INC = 2'd2,
      CMD_ADDR_CLR = 2'd3
   } cmd_t;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE    = 2'd0;
   localparam state_t ST_CMD     = 2'd1;
   localparam state_t ST_WAIT_WR = 2'd2;
   localparam state_t ST_WAIT_RD = 2'd3;

   // Pointer carries one extra wrap bit so full and empty are distinguishable.
   function automatic int fifo_ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// Event queue for decoded key commands: DEPTH entries of cmd_t.
// Push and pop may occur together; a push into a full queue lands only alongside a pop.
module key_evt_fifo
   import key_sched_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  cmd_t push_data,
   input  logic pop,
   output cmd_t pop_data,
   output logic full,
   output logic empty
);

   localparam int PW = fifo_ptr_w(DEPTH);
   localparam int AW = PW - 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("key_evt_fifo: DEPTH must be a power of 2 and >= 2");
   end

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   cmd_t          mem [DEPTH];
   logic          wr_en;
   logic          rd_en;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rd_en    = pop && !empty;
   assign wr_en    = push && (!full || rd_en);
   assign pop_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PW'(1);
         if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/key_cmd_sched.sv
// Turns debounced key pulses into serialized SDRAM write/read requests with req/ack handshakes.
// Optional ack timeout is enabled by defining KEY_SCHED_TIMEOUT_EN.
module key_cmd_sched
   import key_sched_pkg::*;
#(
   parameter int                KEY_W        = 4,
   parameter int                ADDR_W       = 24,
   parameter int                DATA_W       = 16,
   parameter int                FIFO_DEPTH   = 4,
   parameter logic [DATA_W-1:0] PATTERN_INIT = DATA_W'(16'h0001),
   parameter int                TIMEOUT      = 1000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [KEY_W-1:0]  key_vld,
   output logic              wr_req,
   output logic              rd_req,
   output logic [ADDR_W-1:0] sd_addr,
   output logic [DATA_W-1:0] sd_wdata,
   input  logic              sd_ack,
   input  logic [DATA_W-1:0] sd_rdata,
   input  logic              sd_rdata_vld,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_done,
   output logic              busy,
   output logic              evt_drop,
   output logic              timeout_err,
   output state_t            state_dbg
);

   if (KEY_W < 4 || TIMEOUT < 2) begin : g_bad_param
      $error("key_cmd_sched: KEY_W must be >= 4 and TIMEOUT >= 2");
   end

   // Handshake: a request is a level held from the CMD cycle until the cycle after sd_ack;
   // sd_addr/sd_wdata stay constant while it is high, and only one request is ever open.
   state_t            state;
   cmd_t              cmd_q;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] pattern;

   logic evt_vld;
   cmd_t evt_cmd;
   logic fifo_pop;
   cmd_t fifo_data;
   logic fifo_full;
   logic fifo_empty;

   // Lowest set key wins; a multi-key pulse yields exactly one event.
   always_comb begin
      evt_cmd = CMD_WRITE;
      if (key_vld[0])      evt_cmd = CMD_WRITE;
      else if (key_vld[1]) evt_cmd = CMD_READ;
      else if (key_vld[2]) evt_cmd = CMD_ADDR_INC;
      else                 evt_cmd = CMD_ADDR_CLR;
   end

   assign evt_vld   = |key_vld[3:0];
   assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
   assign busy      = (state != ST_IDLE) || !fifo_empty;
   assign state_dbg = state;

   key_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (evt_vld),
      .push_data (evt_cmd),
      .pop       (fifo_pop),
      .pop_data  (fifo_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

`ifdef KEY_SCHED_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT);
   logic [TMO_W-1:0] tmo_cnt;
   logic             tmo_hit;
   assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT - 1));
`else
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         cmd_q    <= CMD_WRITE;
         addr     <= '0;
         pattern  <= PATTERN_INIT;
         wr_req   <= 1'b0;
         rd_req   <= 1'b0;
         sd_addr  <= '0;
         sd_wdata <= '0;
         rd_data  <= '0;
         rd_done  <= 1'b0;
         evt_drop <= 1'b0;
`ifdef KEY_SCHED_TIMEOUT_EN
         tmo_cnt     <= '0;
         timeout_err <= 1'b0;
`endif
      end else begin
         rd_done  <= 1'b0;
         evt_drop <= evt_vld && fifo_full && !fifo_pop;
`ifdef KEY_SCHED_TIMEOUT_EN
         timeout_err <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  cmd_q <= fifo_data;
                  state <= ST_CMD;
               end
            end
            ST_CMD: begin
`ifdef KEY_SCHED_TIMEOUT_EN
               tmo_cnt <= '0;
`endif
               case (cmd_q)
                  CMD_WRITE: begin
                     sd_addr  <= addr;
                     sd_wdata <= pattern;
                     wr_req   <= 1'b1;
                     state    <= ST_WAIT_WR;
                  end
                  CMD_READ: begin
                     sd_addr <= addr;
                     rd_req  <= 1'b1;
                     state   <= ST_WAIT_RD;
                  end
                  CMD_ADDR_INC: begin
                     addr  <= addr + ADDR_W'(1);
                     state <= ST_IDLE;
                  end
                  default: begin
                     addr    <= '0;
                     pattern <= PATTERN_INIT;
                     state   <= ST_IDLE;
                  end
               endcase
            end
            ST_WAIT_WR: begin
               if (sd_ack) begin
                  wr_req  <= 1'b0;
                  pattern <= pattern + DATA_W'(1);
                  state   <= ST_IDLE;
               end
`ifdef KEY_SCHED_TIMEOUT_EN
               else if (tmo_hit) begin
                  wr_req      <= 1'b0;
                  timeout_err <= 1'b1;
                  state       <= ST_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
`endif
            end
            default: begin
               // Capture first so a beat coincident with ack is the one reported.
               if (sd_rdata_vld) rd_data <= sd_rdata;
               if (sd_ack) begin
                  rd_req  <= 1'b0;
                  rd_done <= 1'b1;
                  state   <= ST_IDLE;
               end
`ifdef KEY_SCHED_TIMEOUT_EN
               else if (tmo_hit) begin
                  rd_req      <= 1'b0;
                  timeout_err <= 1'b1;
                  state       <= ST_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
`endif
            end
         endcase
      end
   end

endmodule

// File: tb/tb_key_cmd_sched.sv
// Scoreboard bench for key_cmd_sched: randomized key traffic against a command-level model.
// The timeout scenario runs only when KEY_SCHED_TIMEOUT_EN is defined.
module tb_key_cmd_sched;

   localparam int KEY_W  = 4;
   localparam int ADDR_W = 4;
   localparam int DATA_W = 16;
   localparam int DEPTH  = 4;
   localparam int TMO    = 8;
   localparam int REQ_W  = 1 + ADDR_W + DATA_W;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [KEY_W-1:0]  key_vld;
   logic              wr_req, rd_req;
   logic [ADDR_W-1:0] sd_addr;
   logic [DATA_W-1:0] sd_wdata;
   logic              sd_ack;
   logic [DATA_W-1:0] sd_rdata;
   logic              sd_rdata_vld;
   logic [DATA_W-1:0] rd_data;
   logic              rd_done, busy, evt_drop, timeout_err;
   logic [1:0]        state_dbg;

   key_cmd_sched #(
      .KEY_W(KEY_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH),
      .PATTERN_INIT(16'h0001), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .key_vld(key_vld), .wr_req(wr_req), .rd_req(rd_req),
      .sd_addr(sd_addr), .sd_wdata(sd_wdata), .sd_ack(sd_ack), .sd_rdata(sd_rdata),
      .sd_rdata_vld(sd_rdata_vld), .rd_data(rd_data), .rd_done(rd_done), .busy(busy),
      .evt_drop(evt_drop), .timeout_err(timeout_err), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model: command-level view of address, pattern and expected traffic.
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_pat;
   logic [DATA_W-1:0] m_last_rd;
   logic [REQ_W-1:0]  exp_q[$];
   logic [DATA_W-1:0] exp_rd_q[$];
   int exp_drops = 0, exp_reads = 0, exp_tmo = 0;
   int drop_cnt = 0, rd_done_cnt = 0, tmo_seen = 0;

   logic hold_ack = 1'b0;
   int   resp_delay = -1;
   logic resp_fixed = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_key(input logic [3:0] k);
      int idx;
      idx = -1;
      for (int i = 3; i >= 0; i--) if (k[i]) idx = i;
      case (idx)
         0: begin exp_q.push_back({1'b0, m_addr, m_pat}); m_pat = m_pat + 1'b1; end
         1: begin exp_q.push_back({1'b1, m_addr, {DATA_W{1'b0}}}); exp_reads++; end
         2: m_addr = m_addr + 1'b1;
         3: begin m_addr = '0; m_pat = 16'h0001; end
         default: ;
      endcase
   endtask

   task automatic send_key(input logic [3:0] k);
      key_vld = k;
      model_key(k);
      @(posedge clk); #1;
      key_vld = '0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy || wr_req || rd_req) && n < 300) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 300) begin
         tests++; fails++;
         $display("FAIL idle_wait: still busy after %0d cycles, required idle", n);
      end
   endtask

   // SDRAM controller responder.
   initial begin : responder
      int   d;
      logic is_rd;
      sd_ack = 1'b0; sd_rdata_vld = 1'b0; sd_rdata = '0;
      forever begin
         @(posedge clk); #1;
         if (rst_n && !hold_ack && (wr_req || rd_req)) begin
            is_rd = rd_req;
            d = (resp_delay >= 0) ? resp_delay : $urandom_range(0, 4);
            if (resp_fixed) d = 0;
            repeat (d) begin
               if (is_rd && $urandom_range(0, 2) == 0) begin
                  sd_rdata = DATA_W'($urandom); sd_rdata_vld = 1'b1; m_last_rd = sd_rdata;
               end
               @(posedge clk); #1;
               sd_rdata_vld = 1'b0;
            end
            if (is_rd && (resp_fixed || $urandom_range(0, 1) == 1)) begin
               sd_rdata = resp_fixed ? 16'hBEEF : DATA_W'($urandom);
               sd_rdata_vld = 1'b1; m_last_rd = sd_rdata;
            end
            sd_ack = 1'b1;
            @(posedge clk); #1;
            sd_ack = 1'b0; sd_rdata_vld = 1'b0;
            if (is_rd) exp_rd_q.push_back(m_last_rd);
         end
      end
   end

   // Monitor: pops expectations as the DUT presents requests and completions.
   logic              prev_wr = 1'b0, prev_rd = 1'b0;
   logic [ADDR_W-1:0] cap_addr;
   logic [DATA_W-1:0] cap_data;
   logic [REQ_W-1:0]  e;
   logic [DATA_W-1:0] er;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_wr = 1'b0; prev_rd = 1'b0;
      end else begin
         check("req_exclusive", wr_req & rd_req, 1'b0);
         if ((wr_req && !prev_wr) || (rd_req && !prev_rd)) begin
            if (exp_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_req: wr=%0b rd=%0b addr=%0h, required no request", wr_req, rd_req, sd_addr);
            end else begin
               e = exp_q.pop_front();
               check("req_kind", rd_req, e[REQ_W-1]);
               check("req_addr", sd_addr, e[REQ_W-2 -: ADDR_W]);
               if (wr_req) check("req_wdata", sd_wdata, e[DATA_W-1:0]);
            end
            cap_addr = sd_addr; cap_data = sd_wdata;
         end else if (wr_req || rd_req) begin
            check("addr_stable", sd_addr, cap_addr);
            if (wr_req) check("wdata_stable", sd_wdata, cap_data);
         end
         if (rd_done) begin
            rd_done_cnt++;
            if (exp_rd_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_rd_done: rd_data=%0h, required no completion", rd_data);
            end else begin
               er = exp_rd_q.pop_front();
               check("rd_data", rd_data, er);
            end
         end
         if (evt_drop) drop_cnt++;
         if (timeout_err) tmo_seen++;
         prev_wr = wr_req; prev_rd = rd_req;
      end
   end

   initial begin : main
      int lat, n, len;
      key_vld = '0;
      m_addr = '0; m_pat = 16'h0001; m_last_rd = '0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_wr_req", wr_req, 1'b0);
      check("rst_rd_req", rd_req, 1'b0);
      check("rst_sd_addr", sd_addr, 0);
      check("rst_sd_wdata", sd_wdata, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_busy", busy, 1'b0);
      check("rst_state", state_dbg, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // WRITE with a 5-cycle ack: latency and first two patterns.
      resp_delay = 5;
      key_vld = 4'b0001; model_key(4'b0001);
      @(posedge clk); #1;
      key_vld = '0;
      lat = 0;
      while (!wr_req && lat < 10) begin @(posedge clk); #1; lat++; end
      check("wr_latency", lat, 2);
      wait_idle();
      send_key(4'b0001);
      wait_idle();
      resp_delay = -1;

      // Three INCs then a READ whose data beat coincides with ack.
      send_key(4'b0100); send_key(4'b0100); send_key(4'b0100);
      wait_idle();
      resp_fixed = 1'b1;
      send_key(4'b0010);
      wait_idle();
      resp_fixed = 1'b0;
      check("rd_beef", rd_data, 16'hBEEF);

      // Ack and data beat while idle must be ignored.
      sd_ack = 1'b1; sd_rdata_vld = 1'b1; sd_rdata = 16'h1234;
      @(posedge clk); #1;
      sd_ack = 1'b0; sd_rdata_vld = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("idle_ack_rd_data", rd_data, m_last_rd);
      check("idle_ack_no_req", wr_req | rd_req, 1'b0);

      // Multi-key pulse: only the lowest-index key counts.
      send_key(4'b1010);
      wait_idle();
      send_key(4'b0010);
      wait_idle();

      // Queue overflow: one in service, four queued, one dropped.
      hold_ack = 1'b1;
      n = drop_cnt;
      for (int i = 0; i < 6; i++) begin
         key_vld = 4'b0001;
         if (i < 5) model_key(4'b0001);
         @(posedge clk); #1;
      end
      key_vld = '0;
      repeat (3) @(posedge clk);
      #1;
      exp_drops++;
      check("drop_pulses", drop_cnt - n, 1);
      hold_ack = 1'b0;
      wait_idle();

      // Address wrap then CLR restoring the pattern.
      send_key(4'b1000);
      for (int i = 0; i < (1 << ADDR_W) - 1; i++) begin
         send_key(4'b0100);
         if (i % 3 == 2) wait_idle();
      end
      wait_idle();
      send_key(4'b0001);
      send_key(4'b0100);
      wait_idle();
      send_key(4'b0010);
      wait_idle();
      send_key(4'b1000);
      send_key(4'b0001);
      wait_idle();

`ifdef KEY_SCHED_TIMEOUT_EN
      hold_ack = 1'b1;
      send_key(4'b0001);
      n = 0;
      while (!wr_req && n < 10) begin @(posedge clk); #1; n++; end
      lat = 0;
      while (wr_req && lat < 20) begin @(posedge clk); #1; lat++; end
      check("timeout_len", lat, TMO);
      exp_tmo++;
      m_pat = m_pat - 1'b1;
      hold_ack = 1'b0;
      wait_idle();
      send_key(4'b0001);
      wait_idle();
`endif

      // Randomized bursts of up to three keys.
      for (int it = 0; it < 120; it++) begin
         len = $urandom_range(1, 3);
         for (int j = 0; j < len; j++) send_key(4'($urandom_range(0, 15)));
         wait_idle();
      end

      // Reset while a READ is outstanding.
      hold_ack = 1'b1;
      send_key(4'b0010);
      n = 0;
      while (!rd_req && n < 10) begin @(posedge clk); #1; n++; end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_rd_req", rd_req, 1'b0);
      check("midrst_sd_addr", sd_addr, 0);
      check("midrst_rd_data", rd_data, 0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_state", state_dbg, 0);
      exp_reads--;
      m_addr = '0; m_pat = 16'h0001; m_last_rd = '0;
      exp_q.delete(); exp_rd_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      hold_ack = 1'b0;
      @(posedge clk); #1;
      send_key(4'b0001);
      wait_idle();

      repeat (5) @(posedge clk);
      #1;
      check("exp_q_empty", exp_q.size(), 0);
      check("exp_rd_q_empty", exp_rd_q.size(), 0);
      check("drop_total", drop_cnt, exp_drops);
      check("rd_done_total", rd_done_cnt, exp_reads);
      check("timeout_total", tmo_seen, exp_tmo);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
